// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  // Transaction phase: arbitrate, present request to memory, await response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Which master owns the transaction in flight.
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  // Fill bit for read data returned with a timeout error response.
  localparam logic ERR_RDATA_BIT = 1'b0;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: LSU has priority unless the IFU has been
// passed over LSU_STREAK_MAX times in a row while it was waiting.
module mem_arb_pick (
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic streak_full,
  output logic grant_ifu,
  output logic grant_lsu
);

  // Pick a single winner from the two request valids.
  always_comb begin
    grant_lsu = lsu_valid && !(ifu_valid && streak_full);
    grant_ifu = ifu_valid && !grant_lsu;
  end

endmodule

// File: rtl/mem_arb.sv
// Two-master (IFU, LSU) to one-slave memory arbiter with a single outstanding
// transaction, LSU priority with an IFU anti-starvation streak limit, and a
// response timeout that returns an error strobe to the owning master.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LSU_STREAK_MAX = 4,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch master
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  // load/store master
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  // memory slave
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W   = DATA_W / 8;
  localparam int STREAK_W = (LSU_STREAK_MAX > 0) ? $clog2(LSU_STREAK_MAX + 1) : 1;
  localparam int TIMER_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(LSU_STREAK_MAX);
  localparam logic [TIMER_W-1:0]  TIMER_LIMIT  = TIMER_W'(TIMEOUT_CYC);

  // Registered state and latched request fields
  state_t              state_reg,  state_next;
  owner_t              owner_reg,  owner_next;
  logic                we_reg,     we_next;
  logic [ADDR_W-1:0]   addr_reg,   addr_next;
  logic [DATA_W-1:0]   wdata_reg,  wdata_next;
  logic [MASK_W-1:0]   wmask_reg,  wmask_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic [TIMER_W-1:0]  timer_reg,  timer_next;

  // Arbitration
  logic pick_ifu;
  logic pick_lsu;
  logic streak_full;
  logic arb_en;
  logic grant_ifu;
  logic grant_lsu;

  // Response decode
  logic              resp_ok;
  logic              timeout_hit;
  logic              resp_fire;
  logic              resp_is_err;
  logic [DATA_W-1:0] resp_data;

  logic [1:0]        resp_valid_vec;
  logic [1:0]        resp_err_vec;
  logic [DATA_W-1:0] resp_rdata_vec [2];

  assign streak_full = (streak_reg == STREAK_LIMIT);

  mem_arb_pick u_pick (
    .ifu_valid   (ifu_req_valid),
    .lsu_valid   (lsu_req_valid),
    .streak_full (streak_full),
    .grant_ifu   (pick_ifu),
    .grant_lsu   (pick_lsu)
  );

  // Grants only happen in IDLE and never while reset is asserted, so the
  // ready outputs read 0 during reset even with both valids high.
  assign arb_en    = rst && (state_reg == ST_IDLE);
  assign grant_ifu = arb_en && pick_ifu;
  assign grant_lsu = arb_en && pick_lsu;

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  // Memory request channel drives the latched fields; they cannot move while
  // the request is waiting for mem_req_ready.
  assign mem_req_valid = (state_reg == ST_REQ);
  assign mem_we        = we_reg;
  assign mem_addr      = addr_reg;
  assign mem_wdata     = wdata_reg;
  assign mem_wmask     = wmask_reg;

  // A real response wins over a timeout landing in the same cycle.
  assign resp_ok     = (state_reg == ST_WAIT) && mem_resp_valid;
  assign timeout_hit = (state_reg == ST_WAIT) && (timer_reg == TIMER_LIMIT);
  assign resp_fire   = resp_ok || timeout_hit;
  assign resp_is_err = timeout_hit && !resp_ok;
  assign resp_data   = resp_ok ? mem_rdata : {DATA_W{ERR_RDATA_BIT}};

  // Steer the response to the owning master; the other one sees zeros.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    localparam owner_t THIS_OWNER = (gi == 0) ? OWN_IFU : OWN_LSU;
    logic hit;
    assign hit                = resp_fire && (owner_reg == THIS_OWNER);
    assign resp_valid_vec[gi] = hit;
    assign resp_err_vec[gi]   = hit && resp_is_err;
    assign resp_rdata_vec[gi] = hit ? resp_data : '0;
  end

  assign ifu_resp_valid = resp_valid_vec[0];
  assign ifu_resp_err   = resp_err_vec[0];
  assign ifu_rdata      = resp_rdata_vec[0];
  assign lsu_resp_valid = resp_valid_vec[1];
  assign lsu_resp_err   = resp_err_vec[1];
  assign lsu_rdata      = resp_rdata_vec[1];

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= OWN_IFU;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wmask_reg  <= '0;
      streak_reg <= '0;
      timer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      wmask_reg  <= wmask_next;
      streak_reg <= streak_next;
      timer_reg  <= timer_next;
    end
  end

  // Next-state logic: grant and latch in IDLE, hand off in REQ, time out in WAIT.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    wmask_next  = wmask_reg;
    streak_next = streak_reg;
    timer_next  = timer_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (grant_lsu) begin
          state_next = ST_REQ;
          owner_next = OWN_LSU;
          we_next    = lsu_we;
          addr_next  = lsu_addr;
          wdata_next = lsu_wdata;
          wmask_next = lsu_wmask;
          // The streak only grows while the IFU is actually being passed over.
          if (!ifu_req_valid) begin
            streak_next = '0;
          end else if (!streak_full) begin
            streak_next = streak_reg + STREAK_W'(1);
          end
        end else if (grant_ifu) begin
          state_next  = ST_REQ;
          owner_next  = OWN_IFU;
          we_next     = 1'b0;
          addr_next   = ifu_addr;
          wdata_next  = '0;
          wmask_next  = '0;
          streak_next = '0;
        end
      end

      ST_REQ: begin
        if (mem_req_ready) begin
          state_next = ST_WAIT;
          timer_next = '0;
        end
      end

      ST_WAIT: begin
        if (resp_fire) begin
          state_next = ST_IDLE;
        end else if (timer_reg != TIMER_LIMIT) begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
